// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the LEGv8 multi-cycle control unit.
//   - state_e  : FSM states (FETCH, DECODE, EXEC, MEM, WB, TRAP)
//   - class_e  : decoded instruction class
//   - PAT_*    : casez opcode patterns (instruction bits [31:21])
//   - ALU_* / SE_* : ALU operation and sign-extend selector encodings
//   - TRAP_*   : trap cause codes (meaningful only when CTRL_TRAP_EN is defined)
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_LDUR    = 4'd1,
        CLS_STUR    = 4'd2,
        CLS_ADDREG  = 4'd3,
        CLS_ADDIMM  = 4'd4,
        CLS_SUBREG  = 4'd5,
        CLS_SUBIMM  = 4'd6,
        CLS_ANDREG  = 4'd7,
        CLS_ORRREG  = 4'd8,
        CLS_CBZ     = 4'd9,
        CLS_B       = 4'd10,
        CLS_MOVZ    = 4'd11,
        CLS_LSL     = 4'd12,
        CLS_LSR     = 4'd13
    } class_e;

    // Opcode patterns, listed in match priority order.
    localparam logic [10:0] PAT_LDUR   = 11'b??111000010;
    localparam logic [10:0] PAT_STUR   = 11'b??111000000;
    localparam logic [10:0] PAT_ADDREG = 11'b?0?01011???;
    localparam logic [10:0] PAT_ADDIMM = 11'b?0?10001???;
    localparam logic [10:0] PAT_SUBREG = 11'b?1?01011???;
    localparam logic [10:0] PAT_SUBIMM = 11'b?1?10001???;
    localparam logic [10:0] PAT_ANDREG = 11'b?0001010???;
    localparam logic [10:0] PAT_ORRREG = 11'b?0101010???;
    localparam logic [10:0] PAT_CBZ    = 11'b?011010????;
    localparam logic [10:0] PAT_B      = 11'b?00101?????;
    localparam logic [10:0] PAT_MOVZ   = 11'b110100101??;
    localparam logic [10:0] PAT_LSL    = 11'b11010011011;
    localparam logic [10:0] PAT_LSR    = 11'b11010011010;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_LSL   = 4'b0011;
    localparam logic [3:0] ALU_LSR   = 4'b0100;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    localparam logic [2:0] SE_ITYPE = 3'b000;
    localparam logic [2:0] SE_DTYPE = 3'b001;
    localparam logic [2:0] SE_BTYPE = 3'b010;
    localparam logic [2:0] SE_CBTYPE = 3'b011;
    localparam logic [2:0] SE_SHAMT = 3'b100;
    localparam logic [2:0] SE_MOVZ  = 3'b101;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_IMEM    = 2'b10;
    localparam logic [1:0] TRAP_DMEM    = 2'b11;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode -> instruction class and static datapath
// control fields. Driven from the registered opcode, so nothing here sees the
// live opcode input of the control unit.
//   opcode_i  : registered instruction bits [31:21]
//   cls_o     : decoded class (CLS_ILLEGAL when no pattern matches)
//   reg2loc_o, alusrc_o, aluop_o, signop_o : static controls for the class
import ctrl_pkg::*;

module ctrl_decode #(
    parameter int OPCODE_W = 11,
    parameter int ALUOP_W  = 4,
    parameter int SIGNOP_W = 3
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output class_e              cls_o,
    output logic                reg2loc_o,
    output logic                alusrc_o,
    output logic [ALUOP_W-1:0]  aluop_o,
    output logic [SIGNOP_W-1:0] signop_o
);

    // Priority pattern match: first matching pattern wins.
    always_comb begin
        cls_o = CLS_ILLEGAL;
        casez (opcode_i)
            PAT_LDUR:   cls_o = CLS_LDUR;
            PAT_STUR:   cls_o = CLS_STUR;
            PAT_ADDREG: cls_o = CLS_ADDREG;
            PAT_ADDIMM: cls_o = CLS_ADDIMM;
            PAT_SUBREG: cls_o = CLS_SUBREG;
            PAT_SUBIMM: cls_o = CLS_SUBIMM;
            PAT_ANDREG: cls_o = CLS_ANDREG;
            PAT_ORRREG: cls_o = CLS_ORRREG;
            PAT_CBZ:    cls_o = CLS_CBZ;
            PAT_B:      cls_o = CLS_B;
            PAT_MOVZ:   cls_o = CLS_MOVZ;
            PAT_LSL:    cls_o = CLS_LSL;
            PAT_LSR:    cls_o = CLS_LSR;
            default:    cls_o = CLS_ILLEGAL;
        endcase
    end

    // Static control fields per class; an illegal opcode leaves them all 0.
    always_comb begin
        reg2loc_o = 1'b0;
        alusrc_o  = 1'b0;
        aluop_o   = ALUOP_W'(ALU_AND);
        signop_o  = SIGNOP_W'(SE_ITYPE);
        case (cls_o)
            CLS_LDUR: begin
                alusrc_o = 1'b1;
                aluop_o  = ALUOP_W'(ALU_ADD);
                signop_o = SIGNOP_W'(SE_DTYPE);
            end
            CLS_STUR: begin
                reg2loc_o = 1'b1;
                alusrc_o  = 1'b1;
                aluop_o   = ALUOP_W'(ALU_ADD);
                signop_o  = SIGNOP_W'(SE_DTYPE);
            end
            CLS_ADDREG: aluop_o = ALUOP_W'(ALU_ADD);
            CLS_SUBREG: aluop_o = ALUOP_W'(ALU_SUB);
            CLS_ANDREG: aluop_o = ALUOP_W'(ALU_AND);
            CLS_ORRREG: aluop_o = ALUOP_W'(ALU_ORR);
            CLS_ADDIMM: begin
                alusrc_o = 1'b1;
                aluop_o  = ALUOP_W'(ALU_ADD);
            end
            CLS_SUBIMM: begin
                alusrc_o = 1'b1;
                aluop_o  = ALUOP_W'(ALU_SUB);
            end
            CLS_CBZ: begin
                reg2loc_o = 1'b1;
                aluop_o   = ALUOP_W'(ALU_PASSB);
                signop_o  = SIGNOP_W'(SE_CBTYPE);
            end
            CLS_B: signop_o = SIGNOP_W'(SE_BTYPE);
            CLS_MOVZ: begin
                alusrc_o = 1'b1;
                aluop_o  = ALUOP_W'(ALU_PASSB);
                signop_o = SIGNOP_W'(SE_MOVZ);
            end
            CLS_LSL: begin
                alusrc_o = 1'b1;
                aluop_o  = ALUOP_W'(ALU_LSL);
                signop_o = SIGNOP_W'(SE_SHAMT);
            end
            CLS_LSR: begin
                alusrc_o = 1'b1;
                aluop_o  = ALUOP_W'(ALU_LSR);
                signop_o = SIGNOP_W'(SE_SHAMT);
            end
            default: begin
                reg2loc_o = 1'b0;
                alusrc_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle control unit for the LEGv8 subset datapath.
// Latches the opcode when an instruction is fetched and steps it through
// FETCH/DECODE/EXEC/MEM/WB, waiting on imem_ack/dmem_ack.
// Optional feature macro CTRL_TRAP_EN: illegal opcodes and ack timeouts
// (WAIT_LIMIT ack-less cycles) enter a sticky TRAP state; without it illegal
// opcodes are NOPs, waits are unbounded and trap/trap_cause read 0.
// Ports:
//   CLK, resetl (async, active-low)
//   opcode, imem_ack, dmem_ack          : inputs
//   imem_req, pc_write                  : fetch strobes
//   reg2loc..uncond_branch, aluop, signop : datapath controls
//   instr_done, state_o, trap, trap_cause : status
// Outputs are decoded from state and the opcode register only (plus the ack
// inputs for pc_write/instr_done) and are forced to 0 while resetl is low.
import ctrl_pkg::*;

module multicycle_control #(
    parameter int OPCODE_W   = 11,
    parameter int ALUOP_W    = 4,
    parameter int SIGNOP_W   = 3,
    parameter int WAIT_LIMIT = 16
) (
    input  logic                CLK,
    input  logic                resetl,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                imem_ack,
    input  logic                dmem_ack,
    output logic                imem_req,
    output logic                pc_write,
    output logic                reg2loc,
    output logic                alusrc,
    output logic                mem2reg,
    output logic                regwrite,
    output logic                memread,
    output logic                memwrite,
    output logic                branch,
    output logic                uncond_branch,
    output logic [ALUOP_W-1:0]  aluop,
    output logic [SIGNOP_W-1:0] signop,
    output logic                instr_done,
    output logic [2:0]          state_o,
    output logic                trap,
    output logic [1:0]          trap_cause
);

`ifdef CTRL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    class_e              cls_s;
    logic                dec_reg2loc_s, dec_alusrc_s;
    logic [ALUOP_W-1:0]  dec_aluop_s;
    logic [SIGNOP_W-1:0] dec_signop_s;
    logic                is_mem_s, is_br_s, timeout_s;

    ctrl_decode #(
        .OPCODE_W (OPCODE_W),
        .ALUOP_W  (ALUOP_W),
        .SIGNOP_W (SIGNOP_W)
    ) u_decode (
        .opcode_i  (opcode_q),
        .cls_o     (cls_s),
        .reg2loc_o (dec_reg2loc_s),
        .alusrc_o  (dec_alusrc_s),
        .aluop_o   (dec_aluop_s),
        .signop_o  (dec_signop_s)
    );

    assign is_mem_s = (cls_s == CLS_LDUR) || (cls_s == CLS_STUR);
    assign is_br_s  = (cls_s == CLS_CBZ)  || (cls_s == CLS_B);
    assign state_o  = state_q;

    // Next-state and opcode capture logic.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    state_d  = ST_DECODE;
                    opcode_d = opcode;
                end else if (timeout_s) begin
                    state_d = ST_TRAP;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (cls_s != CLS_ILLEGAL) begin
                    state_d = ST_EXEC;
                end else if (TRAP_EN) begin
                    state_d = ST_TRAP;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (is_mem_s) begin
                    state_d = ST_MEM;
                end else if (is_br_s) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    state_d = (cls_s == CLS_LDUR) ? ST_WB : ST_FETCH;
                end else if (timeout_s) begin
                    state_d = ST_TRAP;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
    end

    // State and opcode registers.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q  <= ST_FETCH;
            opcode_q <= {OPCODE_W{1'b0}};
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

`ifdef CTRL_TRAP_EN
    localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              trap_q;
    logic [1:0]        cause_q, cause_s;

    // wait_q counts ack-less cycles already spent in FETCH/MEM, so an ack in
    // the WAIT_LIMIT-th cycle still wins over the timeout.
    assign timeout_s = (wait_q == WAIT_W'(WAIT_LIMIT - 1));

    // Wait counter: advances only while holding in FETCH/MEM, clears otherwise.
    always_comb begin
        if ((state_d == state_q) && ((state_q == ST_FETCH) || (state_q == ST_MEM))) begin
            wait_d = wait_q + WAIT_W'(1);
        end else begin
            wait_d = {WAIT_W{1'b0}};
        end
    end

    // Trap cause follows from the state the trap is taken from.
    always_comb begin
        if (state_q == ST_DECODE) begin
            cause_s = TRAP_ILLEGAL;
        end else if (state_q == ST_MEM) begin
            cause_s = TRAP_DMEM;
        end else begin
            cause_s = TRAP_IMEM;
        end
    end

    // Wait counter and sticky trap registers.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            wait_q  <= {WAIT_W{1'b0}};
            trap_q  <= 1'b0;
            cause_q <= TRAP_NONE;
        end else begin
            wait_q <= wait_d;
            if ((state_d == ST_TRAP) && (state_q != ST_TRAP)) begin
                trap_q  <= 1'b1;
                cause_q <= cause_s;
            end else begin
                trap_q  <= trap_q;
                cause_q <= cause_q;
            end
        end
    end

    assign trap       = trap_q;
    assign trap_cause = cause_q;
`else
    assign timeout_s  = 1'b0;
    assign trap       = 1'b0;
    assign trap_cause = TRAP_NONE;
`endif

    // Per-state strobes and static controls; everything quiet in reset and TRAP.
    always_comb begin
        imem_req      = 1'b0;
        pc_write      = 1'b0;
        reg2loc       = 1'b0;
        alusrc        = 1'b0;
        mem2reg       = 1'b0;
        regwrite      = 1'b0;
        memread       = 1'b0;
        memwrite      = 1'b0;
        branch        = 1'b0;
        uncond_branch = 1'b0;
        aluop         = {ALUOP_W{1'b0}};
        signop        = {SIGNOP_W{1'b0}};
        instr_done    = 1'b0;
        if (resetl) begin
            if ((state_q == ST_DECODE) || (state_q == ST_EXEC) ||
                (state_q == ST_MEM) || (state_q == ST_WB)) begin
                reg2loc = dec_reg2loc_s;
                alusrc  = dec_alusrc_s;
                aluop   = dec_aluop_s;
                signop  = dec_signop_s;
            end else begin
                reg2loc = 1'b0;
            end
            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    pc_write = imem_ack;
                end
                ST_DECODE: instr_done = (cls_s == CLS_ILLEGAL) && !TRAP_EN;
                ST_EXEC: begin
                    branch        = (cls_s == CLS_CBZ);
                    uncond_branch = (cls_s == CLS_B);
                    instr_done    = is_br_s;
                end
                ST_MEM: begin
                    memread    = (cls_s == CLS_LDUR);
                    memwrite   = (cls_s == CLS_STUR);
                    instr_done = (cls_s == CLS_STUR) && dmem_ack;
                end
                ST_WB: begin
                    regwrite   = 1'b1;
                    mem2reg    = (cls_s == CLS_LDUR);
                    instr_done = 1'b1;
                end
                default: imem_req = 1'b0;
            endcase
        end else begin
            imem_req = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a table of instruction vectors with
// hand-computed controls, strobe counts and latencies, plus hand-written
// sequences for reset, illegal opcodes and (with CTRL_TRAP_EN) timeouts.
module tb_multicycle_control;

    logic        CLK = 1'b0;
    logic        resetl = 1'b0;
    logic [10:0] opcode = 11'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        imem_req, pc_write, reg2loc, alusrc, mem2reg, regwrite;
    logic        memread, memwrite, branch, uncond_branch, instr_done, trap;
    logic [3:0]  aluop;
    logic [2:0]  signop;
    logic [2:0]  state_o;
    logic [1:0]  trap_cause;

    int n_vec = 0;
    int n_bad = 0;

    multicycle_control #(
        .OPCODE_W(11), .ALUOP_W(4), .SIGNOP_W(3), .WAIT_LIMIT(16)
    ) dut (
        .CLK(CLK), .resetl(resetl), .opcode(opcode),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .pc_write(pc_write), .reg2loc(reg2loc),
        .alusrc(alusrc), .mem2reg(mem2reg), .regwrite(regwrite),
        .memread(memread), .memwrite(memwrite), .branch(branch),
        .uncond_branch(uncond_branch), .aluop(aluop), .signop(signop),
        .instr_done(instr_done), .state_o(state_o), .trap(trap),
        .trap_cause(trap_cause)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [10:0] op;
        int          iwait;   // cycles without imem_ack before the ack
        int          dwait;   // MEM cycles before dmem_ack (-1: no MEM state)
        logic [3:0]  aluop;
        logic [2:0]  signop;
        logic        r2l;
        logic        asrc;
        int          cycles;  // FETCH through final cycle
        int          n_rw, n_m2r, n_mr, n_mw, n_br, n_ub;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic [10:0] op, input int iw, input int dw,
                                input logic [3:0] al, input logic [2:0] sg,
                                input logic r2, input logic as, input int cy,
                                input int rw, input int m2, input int mr,
                                input int mw, input int br, input int ub);
        vec_t v;
        v.op = op; v.iwait = iw; v.dwait = dw; v.aluop = al; v.signop = sg;
        v.r2l = r2; v.asrc = as; v.cycles = cy; v.n_rw = rw; v.n_m2r = m2;
        v.n_mr = mr; v.n_mw = mw; v.n_br = br; v.n_ub = ub;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Starts just after a negedge with the DUT in FETCH; ends just after the
    // negedge following the instruction's final cycle.
    task automatic run_vec(input int idx, input vec_t v);
        int done_k = 0;
        int c_ir = 0, c_pw = 0, c_rw = 0, c_m2r = 0, c_mr = 0, c_mw = 0, c_br = 0, c_ub = 0;
        string p;
        p = $sformatf("v%0d", idx);
        for (int k = 1; k <= 40 && done_k == 0; k++) begin
            // Opcode is garbage once fetched: controls must come from the register.
            opcode   = (k <= 1 + v.iwait) ? v.op : 11'b00000000000;
            imem_ack = (k == 1 + v.iwait);
            dmem_ack = (v.dwait >= 0) && (k == 4 + v.iwait + v.dwait);
            #1;
            c_ir  += int'(imem_req);  c_pw  += int'(pc_write);
            c_rw  += int'(regwrite);  c_m2r += int'(mem2reg);
            c_mr  += int'(memread);   c_mw  += int'(memwrite);
            c_br  += int'(branch);    c_ub  += int'(uncond_branch);
            if (k == 1) chk({p, " fetch state"}, state_o, 3'd0);
            if (k == 2 + v.iwait) begin
                chk({p, " decode state"}, state_o, 3'd1);
                chk({p, " aluop"}, aluop, v.aluop);
                chk({p, " signop"}, signop, v.signop);
                chk({p, " reg2loc"}, reg2loc, v.r2l);
                chk({p, " alusrc"}, alusrc, v.asrc);
            end
            if (instr_done) begin
                done_k = k;
                chk({p, " aluop held"}, aluop, v.aluop);
            end
            @(negedge CLK);
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        chk({p, " cycles"}, done_k, v.cycles);
        chk({p, " imem_req cycles"}, c_ir, 1 + v.iwait);
        chk({p, " pc_write cycles"}, c_pw, 1);
        chk({p, " regwrite cycles"}, c_rw, v.n_rw);
        chk({p, " mem2reg cycles"}, c_m2r, v.n_m2r);
        chk({p, " memread cycles"}, c_mr, v.n_mr);
        chk({p, " memwrite cycles"}, c_mw, v.n_mw);
        chk({p, " branch cycles"}, c_br, v.n_br);
        chk({p, " uncond cycles"}, c_ub, v.n_ub);
        #1 chk({p, " back to fetch"}, state_o, 3'd0);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        resetl   = 1'b0;
        @(negedge CLK);
        resetl = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //           opcode           iw  dw aluop    signop  r2l   asrc  cyc rw m2r mr mw br ub
        vecs[0]  = mk(11'b10001011000, 0, -1, 4'b0010, 3'b000, 1'b0, 1'b0, 4, 1, 0, 0, 0, 0, 0); // ADD
        vecs[1]  = mk(11'b11111000010, 0,  3, 4'b0010, 3'b001, 1'b0, 1'b1, 8, 1, 1, 4, 0, 0, 0); // LDUR
        vecs[2]  = mk(11'b11111000010, 0,  0, 4'b0010, 3'b001, 1'b0, 1'b1, 5, 1, 1, 1, 0, 0, 0); // LDUR
        vecs[3]  = mk(11'b11111000000, 0,  0, 4'b0010, 3'b001, 1'b1, 1'b1, 4, 0, 0, 0, 1, 0, 0); // STUR
        vecs[4]  = mk(11'b11111000000, 1,  2, 4'b0010, 3'b001, 1'b1, 1'b1, 7, 0, 0, 0, 3, 0, 0); // STUR
        vecs[5]  = mk(11'b11001011000, 0, -1, 4'b0110, 3'b000, 1'b0, 1'b0, 4, 1, 0, 0, 0, 0, 0); // SUB
        vecs[6]  = mk(11'b10010001000, 0, -1, 4'b0010, 3'b000, 1'b0, 1'b1, 4, 1, 0, 0, 0, 0, 0); // ADDI
        vecs[7]  = mk(11'b11010001000, 0, -1, 4'b0110, 3'b000, 1'b0, 1'b1, 4, 1, 0, 0, 0, 0, 0); // SUBI
        vecs[8]  = mk(11'b10001010000, 0, -1, 4'b0000, 3'b000, 1'b0, 1'b0, 4, 1, 0, 0, 0, 0, 0); // AND
        vecs[9]  = mk(11'b10101010000, 0, -1, 4'b0001, 3'b000, 1'b0, 1'b0, 4, 1, 0, 0, 0, 0, 0); // ORR
        vecs[10] = mk(11'b10110100101, 0, -1, 4'b0111, 3'b011, 1'b1, 1'b0, 3, 0, 0, 0, 0, 1, 0); // CBZ
        vecs[11] = mk(11'b00010100000, 0, -1, 4'b0000, 3'b010, 1'b0, 1'b0, 3, 0, 0, 0, 0, 0, 1); // B
        vecs[12] = mk(11'b11010010100, 0, -1, 4'b0111, 3'b101, 1'b0, 1'b1, 4, 1, 0, 0, 0, 0, 0); // MOVZ
        vecs[13] = mk(11'b11010011011, 0, -1, 4'b0011, 3'b100, 1'b0, 1'b1, 4, 1, 0, 0, 0, 0, 0); // LSL
        vecs[14] = mk(11'b11010011010, 0, -1, 4'b0100, 3'b100, 1'b0, 1'b1, 4, 1, 0, 0, 0, 0, 0); // LSR
        vecs[15] = mk(11'b10001011000, 2, -1, 4'b0010, 3'b000, 1'b0, 1'b0, 6, 1, 0, 0, 0, 0, 0); // ADD

        // Reset: every output 0 even with imem_ack high.
        resetl   = 1'b0;
        imem_ack = 1'b1;
        repeat (2) @(negedge CLK);
        #1 chk("reset outputs", {8'h00, imem_req, pc_write, reg2loc, alusrc, mem2reg,
               regwrite, memread, memwrite, branch, uncond_branch, aluop, signop,
               instr_done, state_o, trap, trap_cause}, 32'h0);
        @(negedge CLK);
        imem_ack = 1'b0;
        resetl   = 1'b1;
        #1 chk("post-reset imem_req", imem_req, 1'b1);
        chk("post-reset state", state_o, 3'd0);
        @(negedge CLK);

        for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

        // Reset during MEM of STUR: memwrite must drop without a clock edge.
        opcode   = 11'b11111000000;
        imem_ack = 1'b1;
        @(negedge CLK);
        imem_ack = 1'b0;
        repeat (2) @(negedge CLK);
        #1 chk("stur mem state", state_o, 3'd3);
        chk("stur memwrite", memwrite, 1'b1);
        #2 resetl = 1'b0;
        #1 chk("stur async memwrite", memwrite, 1'b0);
        chk("stur async state", state_o, 3'd0);
        chk("stur async regwrite", regwrite, 1'b0);
        @(negedge CLK);
        resetl = 1'b1;
        #1 chk("stur post-reset imem_req", imem_req, 1'b1);
        chk("stur post-reset state", state_o, 3'd0);

`ifdef CTRL_TRAP_EN
        // Illegal opcode traps after DECODE.
        do_reset();
        opcode   = 11'b00000000000;
        imem_ack = 1'b1;
        @(negedge CLK);
        imem_ack = 1'b0;
        #1 chk("ill decode state", state_o, 3'd1);
        @(negedge CLK);
        #1 chk("ill trap state", state_o, 3'd5);
        chk("ill trap", trap, 1'b1);
        chk("ill cause", trap_cause, 2'b01);
        repeat (3) @(negedge CLK);
        #1 chk("ill trap strobes", {imem_req, pc_write, regwrite, memread, memwrite, instr_done}, 6'b0);
        chk("ill trap sticky", {trap, trap_cause}, 3'b101);
        do_reset();
        #1 chk("trap cleared", {trap, trap_cause}, 3'b000);

        // imem timeout: 16 ack-less cycles, then TRAP.
        repeat (15) @(negedge CLK);
        #1 chk("imem wait 16 state", state_o, 3'd0);
        @(negedge CLK);
        #1 chk("imem timeout state", state_o, 3'd5);
        chk("imem timeout cause", {trap, trap_cause}, 3'b110);

        // Ack in the 16th wait cycle is still accepted.
        do_reset();
        opcode = 11'b10001011000;
        repeat (15) @(negedge CLK);
        imem_ack = 1'b1;
        @(negedge CLK);
        imem_ack = 1'b0;
        #1 chk("late ack state", state_o, 3'd1);
        chk("late ack trap", trap, 1'b0);
        repeat (2) @(negedge CLK);
        #1 chk("late ack wb done", {regwrite, instr_done}, 2'b11);

        // dmem timeout during LDUR MEM.
        do_reset();
        opcode   = 11'b11111000010;
        imem_ack = 1'b1;
        @(negedge CLK);
        imem_ack = 1'b0;
        repeat (2) @(negedge CLK);
        #1 chk("dmem wait mem", state_o, 3'd3);
        repeat (16) @(negedge CLK);
        #1 chk("dmem timeout state", state_o, 3'd5);
        chk("dmem timeout cause", {trap, trap_cause}, 3'b111);
        chk("dmem timeout memread", memread, 1'b0);
`else
        // Illegal opcode is a NOP: DECODE with instr_done, then FETCH.
        do_reset();
        opcode   = 11'b00000000000;
        imem_ack = 1'b1;
        @(negedge CLK);
        imem_ack = 1'b0;
        #1 chk("nop decode state", state_o, 3'd1);
        chk("nop instr_done", instr_done, 1'b1);
        chk("nop regwrite", regwrite, 1'b0);
        @(negedge CLK);
        #1 chk("nop next fetch", state_o, 3'd0);
        chk("nop imem_req", imem_req, 1'b1);

        // Unbounded wait: still FETCH and no trap after 20 ack-less cycles.
        repeat (20) @(negedge CLK);
        #1 chk("long wait state", state_o, 3'd0);
        chk("long wait trap", {trap, trap_cause}, 3'b000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
